// File: rtl/pdm_cic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_cic_ctrl
//  Description : Sequencer between the PDM microphone pins and a shared,
//                multi-channel CIC decimator. It generates the PDM bit clock,
//                captures up to 4 channels (2 data lines x 2 clock edges) and
//                feeds them to the CIC as one per-channel valid burst per PDM
//                period. Each decimated PCM word is tagged with its channel
//                and buffered in a first-word-fall-through FIFO.
//  Optional    : PDM_CIC_CTRL_SWAP_EN adds cfg_swap_i, which swaps the capture
//                edges for microphones with inverted L/R select.
//  Ports       : clk_i/rstn_i       clock, async active-low reset
//                cfg_*              enable, channel count-1, clock divider,
//                                   overflow clear (and optional swap)
//                pdm_clk_o/pdm_data_i  microphone interface
//                cic_*              CIC enable, bit, strobe and PCM return
//                data_o/ch_o/valid_o/ready_i  PCM output stream
//                ovf_o              sticky FIFO overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_cic_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PCM_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [1:0]           cfg_ch_num_i,
    input  logic [7:0]           cfg_clkdiv_i,
    input  logic                 cfg_ovf_clr_i,
`ifdef PDM_CIC_CTRL_SWAP_EN
    input  logic                 cfg_swap_i,
`endif
    output logic                 pdm_clk_o,
    input  logic [1:0]           pdm_data_i,
    output logic                 cic_en_o,
    output logic                 cic_data_o,
    output logic                 cic_valid_o,
    input  logic [PCM_WIDTH-1:0] cic_pcm_i,
    input  logic                 cic_pcm_valid_i,
    output logic [PCM_WIDTH-1:0] data_o,
    output logic [1:0]           ch_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ovf_o
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_W  = PCM_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    logic            r_en;
    logic [7:0]      r_div_cnt;
    logic            r_pdm_clk;
    logic [3:0]      r_cap;
    logic [3:0]      r_sh;
    logic [1:0]      r_ch_idx;
    state_t          r_state;
    logic [c_AW:0]   r_wr;
    logic [c_AW:0]   r_rd;
    logic            r_ovf;
    logic [c_W-1:0]  r_mem [FIFO_DEPTH];

    logic            w_en_rise;
    logic [7:0]      w_div_max;
    logic            w_tick;
    logic            w_rise_tog;
    logic            w_fall_tog;
    logic            w_swap;
    logic            w_fill_odd;
    logic            w_fill_even;
    logic [3:0]      w_cap_nxt;
    logic            w_cic_valid;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_ovf_set;
    logic [c_W-1:0]  w_head;

    assign w_en_rise  = cfg_en_i & ~r_en;
    assign w_div_max  = (cfg_clkdiv_i == 8'd0) ? 8'd1 : cfg_clkdiv_i;
    assign w_tick     = r_en & (r_div_cnt == w_div_max);
    assign w_rise_tog = w_tick & ~r_pdm_clk;
    assign w_fall_tog = w_tick &  r_pdm_clk;

`ifdef PDM_CIC_CTRL_SWAP_EN
    assign w_swap = cfg_swap_i;
`else
    assign w_swap = 1'b0;
`endif

    // Odd slots (cap[1]/cap[3]) normally hold data driven in the low phase,
    // sampled on the rising toggle; even slots come from the falling toggle.
    assign w_fill_odd  = w_swap ? w_fall_tog : w_rise_tog;
    assign w_fill_even = w_swap ? w_rise_tog : w_fall_tog;

    always_comb begin
        w_cap_nxt = r_cap;
        if (w_fill_odd) begin
            w_cap_nxt[1] = pdm_data_i[0];
            w_cap_nxt[3] = pdm_data_i[1];
        end
        if (w_fill_even) begin
            w_cap_nxt[0] = pdm_data_i[0];
            w_cap_nxt[2] = pdm_data_i[1];
        end
    end

    // Enable register, divider and capture registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en      <= 1'b0;
            r_div_cnt <= 8'd0;
            r_pdm_clk <= 1'b0;
            r_cap     <= 4'd0;
        end else begin
            r_en  <= cfg_en_i;
            r_cap <= w_cap_nxt;
            if (!r_en) begin
                r_div_cnt <= 8'd0;
                r_pdm_clk <= 1'b0;
            end else if (w_tick) begin
                r_div_cnt <= 8'd0;
                r_pdm_clk <= ~r_pdm_clk;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
        end
    end

    // Burst sequencer. The shadow takes the capture values including the
    // bits sampled on the falling toggle itself, so every burst carries the
    // period that just completed. When a burst is exactly one PDM period
    // long the next falling toggle lands on its last cycle, so the burst is
    // restarted directly instead of passing through WAIT.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_ch_idx <= 2'd0;
            r_sh     <= 4'd0;
        end else if (!r_en) begin
            r_state  <= S_IDLE;
            r_ch_idx <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_WAIT;
                    r_ch_idx <= 2'd0;
                end
                S_WAIT: begin
                    if (w_fall_tog) begin
                        r_sh     <= w_cap_nxt;
                        r_ch_idx <= 2'd0;
                        r_state  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (r_ch_idx == cfg_ch_num_i) begin
                        r_ch_idx <= 2'd0;
                        if (w_fall_tog) begin
                            r_sh    <= w_cap_nxt;
                            r_state <= S_BURST;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_ch_idx <= r_ch_idx + 2'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ch_idx <= 2'd0;
                end
            endcase
        end
    end

    // Strobe drops in the same cycle the enable input falls.
    assign w_cic_valid = (r_state == S_BURST) & r_en & cfg_en_i;

    assign pdm_clk_o   = r_pdm_clk;
    assign cic_en_o    = r_en;
    assign cic_valid_o = w_cic_valid;
    assign cic_data_o  = w_cic_valid & r_sh[r_ch_idx];

    // Output FIFO: pointers carry one extra wrap bit to tell full from empty
    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) &&
                       (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_push    = cic_pcm_valid_i & w_cic_valid;
    assign w_pop     = ~w_empty & ready_i;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_en_rise) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push_ok) r_wr <= r_wr + 1'b1;
                if (w_pop)     r_rd <= r_rd + 1'b1;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (cfg_ovf_clr_i || w_en_rise)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok)
            r_mem[r_wr[c_AW-1:0]] <= {r_ch_idx, cic_pcm_i};
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign w_head  = r_mem[r_rd[c_AW-1:0]];
    assign valid_o = ~w_empty;
    assign data_o  = w_empty ? '0   : w_head[PCM_WIDTH-1:0];
    assign ch_o    = w_empty ? 2'd0 : w_head[c_W-1 -: 2];
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire
